// File: rtl/b1_vec_pipe_if.sv
// Handshake and payload bundle for b1_vec_pipe: stimulus side (master) and pipeline side (slave).
interface b1_vec_pipe_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic             cnt_clr;
  logic [CNT_W-1:0] f_count;

  modport master (
    output in_valid, a, b, c, out_ready, cnt_clr,
    input  in_ready, out_valid, d, e, f, g, f_count
  );

  modport slave (
    input  in_valid, a, b, c, out_ready, cnt_clr,
    output in_ready, out_valid, d, e, f, g, f_count
  );
endinterface

// File: rtl/b1_vec_pipe.sv
// Lane-wise b1 equations carried through a STAGES-deep elastic valid/ready pipeline,
// with a saturating popcount of delivered f bits.
module b1_vec_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  b1_vec_pipe_if.slave bus
);
  localparam int unsigned POP_W = $clog2(WIDTH + 1);

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [WIDTH-1:0]  r_e [STAGES];
  logic [WIDTH-1:0]  r_f [STAGES];
  logic [WIDTH-1:0]  r_g [STAGES];
  logic [CNT_W-1:0]  r_cnt;

  logic [STAGES-1:0] w_adv;
  logic [WIDTH-1:0]  w_d;
  logic [WIDTH-1:0]  w_e;
  logic [WIDTH-1:0]  w_f;
  logic [WIDTH-1:0]  w_g;
  logic [POP_W-1:0]  w_pop;
  logic [CNT_W:0]    w_sum;
  logic              w_out_hs;

  assign w_d = bus.c;
  assign w_e = bus.a ^ bus.b;
  assign w_f = (bus.c & ~bus.a & ~bus.b) | (~bus.c & bus.a & bus.b);
  assign w_g = ~bus.c;

  // A stage moves when the sink takes a beat or any stage at or below it has a hole.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      w_adv[k] = bus.out_ready;
      for (int j = k; j < int'(STAGES); j++) begin
        if (!r_vld[j]) w_adv[k] = 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_adv[0];
  assign w_out_hs      = r_vld[STAGES-1] & bus.out_ready;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.d         = r_d[STAGES-1];
  assign bus.e         = r_e[STAGES-1];
  assign bus.f         = r_f[STAGES-1];
  assign bus.g         = r_g[STAGES-1];
  assign bus.f_count   = r_cnt;

  // Payload registers only load on a valid beat so idle stages keep their last data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_d[k] <= '0;
        r_e[k] <= '0;
        r_f[k] <= '0;
        r_g[k] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= bus.in_valid;
        if (bus.in_valid) begin
          r_d[0] <= w_d;
          r_e[0] <= w_e;
          r_f[0] <= w_f;
          r_g[0] <= w_g;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_d[k] <= r_d[k-1];
            r_e[k] <= r_e[k-1];
            r_f[k] <= r_f[k-1];
            r_g[k] <= r_g[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pop = w_pop + POP_W'(r_f[STAGES-1][i]);
    end
    w_sum = {1'b0, r_cnt} + (CNT_W + 1)'(w_pop);
  end

  // One extra sum bit is enough: a single beat adds at most WIDTH < 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_hs) begin
      r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_b1_vec_pipe.sv
// Directed and random checks of b1_vec_pipe at several WIDTH/STAGES points, scoreboard-based.
module tb_b1_vec_pipe;
  typedef struct packed {
    logic [3:0] d;
    logic [3:0] e;
    logic [3:0] f;
    logic [3:0] g;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   out3_cnt;
  int   out1_cnt;
  int   out4_cnt;
  int   idx;
  logic acc;
  logic [8:0] v;
  logic [3:0] bp_a [4];
  logic [3:0] bp_b [4];
  logic [3:0] bp_c [4];
  int unsigned sat_exp [7];
  res_t q1[$];
  res_t q2[$];
  res_t q3[$];
  res_t q4[$];
  res_t exp_r;

  b1_vec_pipe_if #(.WIDTH(4), .CNT_W(4))  if2 ();
  b1_vec_pipe_if #(.WIDTH(3), .CNT_W(16)) if3 ();
  b1_vec_pipe_if #(.WIDTH(4), .CNT_W(8))  if1 ();
  b1_vec_pipe_if #(.WIDTH(4), .CNT_W(8))  if4 ();

  b1_vec_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  b1_vec_pipe #(.WIDTH(3), .STAGES(2), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  b1_vec_pipe #(.WIDTH(4), .STAGES(1), .CNT_W(8))  u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  b1_vec_pipe #(.WIDTH(4), .STAGES(4), .CNT_W(8))  u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] m);
    res_t r;
    r.d = c & m;
    r.e = (a ^ b) & m;
    r.f = ((c & ~a & ~b) | (~c & a & b)) & m;
    r.g = ~c & m;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.cnt_clr = 1'b0;
    if1.a = '0; if1.b = '0; if1.c = '0;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1; if2.cnt_clr = 1'b0;
    if2.a = '0; if2.b = '0; if2.c = '0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b1; if3.cnt_clr = 1'b0;
    if3.a = '0; if3.b = '0; if3.c = '0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1; if4.cnt_clr = 1'b0;
    if4.a = '0; if4.b = '0; if4.c = '0;
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (if2.in_valid && if2.in_ready) q2.push_back(model(if2.a, if2.b, if2.c, 4'hF));
      if (if2.out_valid && if2.out_ready) begin
        check("s2_beat_expected", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) begin
          exp_r = q2.pop_front();
          check("s2_beat", 32'({if2.d, if2.e, if2.f, if2.g}), 32'(exp_r));
        end
      end
      if (if3.in_valid && if3.in_ready)
        q3.push_back(model({1'b0, if3.a}, {1'b0, if3.b}, {1'b0, if3.c}, 4'h7));
      if (if3.out_valid && if3.out_ready) begin
        out3_cnt++;
        check("w3_beat_expected", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
          exp_r = q3.pop_front();
          check("w3_beat", 32'({1'b0, if3.d, 1'b0, if3.e, 1'b0, if3.f, 1'b0, if3.g}), 32'(exp_r));
        end
      end
      if (if1.in_valid && if1.in_ready) q1.push_back(model(if1.a, if1.b, if1.c, 4'hF));
      if (if1.out_valid && if1.out_ready) begin
        out1_cnt++;
        check("s1_beat_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          exp_r = q1.pop_front();
          check("s1_beat", 32'({if1.d, if1.e, if1.f, if1.g}), 32'(exp_r));
        end
      end
      if (if4.in_valid && if4.in_ready) q4.push_back(model(if4.a, if4.b, if4.c, 4'hF));
      if (if4.out_valid && if4.out_ready) begin
        out4_cnt++;
        check("s4_beat_expected", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
          exp_r = q4.pop_front();
          check("s4_beat", 32'({if4.d, if4.e, if4.f, if4.g}), 32'(exp_r));
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    out1_cnt = 0; out3_cnt = 0; out4_cnt = 0;
    bp_a = '{4'h3, 4'h5, 4'hC, 4'h9};
    bp_b = '{4'h6, 4'hF, 4'h0, 4'hA};
    bp_c = '{4'h1, 4'h7, 4'hE, 4'h2};
    sat_exp = '{0, 0, 4, 8, 12, 15, 15};
    idle_all();
    rst = 1'b1;
    #12;
    check("rst_out_valid", 32'(if2.out_valid), 32'd0);
    check("rst_f_count",   32'(if2.f_count),   32'd0);
    check("rst_dout",      32'({if2.d, if2.e, if2.f, if2.g}), 32'd0);
    check("rst_s4_valid",  32'(if4.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(if2.in_ready),  32'd1);
    tick();

    // Single beat, two-cycle latency.
    if2.a = 4'b1100; if2.b = 4'b1010; if2.c = 4'b0110; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    check("single_lat1_valid", 32'(if2.out_valid), 32'd0);
    tick();
    check("single_valid", 32'(if2.out_valid), 32'd1);
    check("single_d", 32'(if2.d), 32'b0110);
    check("single_e", 32'(if2.e), 32'b0110);
    check("single_f", 32'(if2.f), 32'b1000);
    check("single_g", 32'(if2.g), 32'b1001);
    check("single_cnt_pre", 32'(if2.f_count), 32'd0);
    tick();
    check("single_cnt", 32'(if2.f_count), 32'd1);
    check("single_drained", 32'(if2.out_valid), 32'd0);

    // Exhaustive 3-lane stream.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      if3.a = v[8:6]; if3.b = v[5:3]; if3.c = v[2:0]; if3.in_valid = 1'b1;
      if (!if3.in_ready) check("exh_in_ready", 32'(if3.in_ready), 32'd1);
      tick();
    end
    if3.in_valid = 1'b0;
    tick();
    tick();
    check("exh_out_count", 32'(out3_cnt), 32'd512);
    check("exh_queue_empty", 32'(q3.size()), 32'd0);

    // Backpressure: pipeline fills, head beat holds.
    if2.out_ready = 1'b0;
    #1;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (idx < 4) begin
        if2.a = bp_a[idx]; if2.b = bp_b[idx]; if2.c = bp_c[idx]; if2.in_valid = 1'b1;
      end
      acc = if2.in_ready;
      check("bp_in_ready", 32'(acc), 32'(cyc < 2));
      if (cyc >= 2) begin
        check("bp_head_valid", 32'(if2.out_valid), 32'd1);
        check("bp_head_d", 32'(if2.d), 32'(bp_c[0]));
        check("bp_head_e", 32'(if2.e), 32'(bp_a[0] ^ bp_b[0]));
      end
      if (acc) idx++;
      tick();
    end
    check("bp_accepted", 32'(idx), 32'd2);
    if2.out_ready = 1'b1;
    for (int n = 0; n < 10 && idx < 4; n++) begin
      if2.a = bp_a[idx]; if2.b = bp_b[idx]; if2.c = bp_c[idx]; if2.in_valid = 1'b1;
      #1;
      acc = if2.in_ready;
      if (acc) idx++;
      tick();
    end
    if2.in_valid = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd4);
    repeat (4) tick();
    check("bp_queue_empty", 32'(q2.size()), 32'd0);

    // Saturation at 15 with CNT_W=4.
    if2.cnt_clr = 1'b1;
    tick();
    if2.cnt_clr = 1'b0;
    check("sat_clr", 32'(if2.f_count), 32'd0);
    if2.a = 4'h0; if2.b = 4'h0; if2.c = 4'hF;
    for (int i = 1; i <= 7; i++) begin
      if2.in_valid = (i <= 5);
      tick();
      check("sat_cnt", 32'(if2.f_count), 32'(sat_exp[i-1]));
    end
    if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    tick();
    check("clr_hs_valid", 32'(if2.out_valid), 32'd1);
    if2.cnt_clr = 1'b1;
    tick();
    if2.cnt_clr = 1'b0;
    check("clr_hs_cnt", 32'(if2.f_count), 32'd0);
    check("clr_hs_consumed", 32'(if2.out_valid), 32'd0);

    // Asynchronous reset with beats in flight.
    if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_cnt", 32'(if2.f_count), 32'd4);
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1;
    tick();
    tick();
    if2.in_valid = 1'b0;
    check("pre_rst_full", 32'(if2.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(if2.out_valid), 32'd0);
    check("arst_f_count", 32'(if2.f_count), 32'd0);
    check("arst_d", 32'(if2.d), 32'd0);
    q1.delete(); q2.delete(); q3.delete(); q4.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    if2.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(if2.in_ready), 32'd1);
    if2.a = 4'b1100; if2.b = 4'b1010; if2.c = 4'b0110; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    check("post_rst_lat1", 32'(if2.out_valid), 32'd0);
    tick();
    check("post_rst_lat2", 32'(if2.out_valid), 32'd1);
    check("post_rst_f", 32'(if2.f), 32'b1000);
    tick();

    // Random valid/ready on STAGES=1 and STAGES=4.
    for (int n = 0; n < 800; n++) begin
      if1.in_valid = 1'($urandom_range(0, 1));
      if1.a = 4'($urandom); if1.b = 4'($urandom); if1.c = 4'($urandom);
      if1.out_ready = ($urandom_range(0, 3) != 0);
      if4.in_valid = ($urandom_range(0, 3) != 0);
      if4.a = 4'($urandom); if4.b = 4'($urandom); if4.c = 4'($urandom);
      if4.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    repeat (8) tick();
    check("rnd_s1_drained", 32'(q1.size()), 32'd0);
    check("rnd_s4_drained", 32'(q4.size()), 32'd0);
    check("rnd_s1_traffic", 32'(out1_cnt > 100), 32'd1);
    check("rnd_s4_traffic", 32'(out4_cnt > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
